// File: rtl/snes_joy_serializer.sv
// Multi-port SNES joypad serializer: synchronises and debounces raw buttons,
// applies per-button turbo, and shifts each port out to the core LSB first.
module snes_joy_serializer #(
   parameter int C_ports         = 2,
   parameter int C_bits          = 16,
   parameter int C_debounce_bits = 16,
   parameter int C_turbo_bits    = 21
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [C_ports*C_bits-1:0]  buttons_n,
   input  logic [C_ports*C_bits-1:0]  turbo_mask,
   input  logic                       joy_strb,
   input  logic [C_ports-1:0]         joy_clk,
   output logic [C_ports*2-1:0]       joy_di,
   output logic [C_ports*C_bits-1:0]  state_n
);

   localparam int N = C_ports * C_bits;
   localparam logic [C_turbo_bits-1:0] TURBO_ONE = 1;

   logic [N-1:0]            sync1_q, sync2_q;
   logic [N-1:0]            hist0_q, hist1_q;
   logic [N-1:0]            deb_q, deb_d;
   logic [N-1:0]            eff_n;
   logic [N-1:0]            state_q;
   logic [N-1:0]            sr_q, sr_d;
   logic [C_ports-1:0]      joy_clk_last_q;
   logic [C_turbo_bits-1:0] turbo_q;
   logic                    tick;
   logic                    phase;

   generate
      if (C_debounce_bits == 0) begin : g_no_prescale
         assign tick = 1'b1;
      end else begin : g_prescale
         localparam logic [C_debounce_bits-1:0] PRE_ONE = 1;
         logic [C_debounce_bits-1:0] pre_q;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) pre_q <= '0;
            else       pre_q <= pre_q + PRE_ONE;
         end
         assign tick = (pre_q == '0);
      end
   endgenerate

   // A bit changes only after three consecutive ticks agree on the new level.
   always_comb begin
      deb_d = (sync2_q & hist0_q & hist1_q) | (deb_q & (sync2_q | hist0_q | hist1_q));
   end

   assign phase = turbo_q[C_turbo_bits-1];
   assign eff_n = deb_q | (turbo_mask & {N{phase}});

   always_comb begin
      sr_d = sr_q;
      for (int p = 0; p < C_ports; p++) begin
         if (joy_strb)
            sr_d[p*C_bits +: C_bits] = eff_n[p*C_bits +: C_bits];
         else if (joy_clk[p] && !joy_clk_last_q[p])
            sr_d[p*C_bits +: C_bits] = {1'b0, sr_q[p*C_bits+1 +: C_bits-1]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q        <= '1;
         sync2_q        <= '1;
         hist0_q        <= '1;
         hist1_q        <= '1;
         deb_q          <= '1;
         state_q        <= '1;
         sr_q           <= '1;
         joy_clk_last_q <= '1;
         turbo_q        <= '0;
      end else begin
         sync1_q        <= buttons_n;
         sync2_q        <= sync1_q;
         if (tick) begin
            hist0_q <= sync2_q;
            hist1_q <= hist0_q;
            deb_q   <= deb_d;
         end
         state_q        <= eff_n;
         sr_q           <= sr_d;
         joy_clk_last_q <= joy_clk;
         turbo_q        <= turbo_q + TURBO_ONE;
      end
   end

   always_comb begin
      joy_di = '1;
      for (int p = 0; p < C_ports; p++)
         joy_di[p*2 +: 2] = {1'b1, sr_q[p*C_bits]};
   end

   assign state_n = state_q;

endmodule

// File: tb/tb_snes_joy_serializer.sv
// Scoreboard bench for snes_joy_serializer: two ports, fast debounce and turbo.
module tb_snes_joy_serializer;

   localparam int P = 2;
   localparam int B = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic [P*B-1:0] buttons_n;
   logic [P*B-1:0] turbo_mask;
   logic         joy_strb;
   logic [P-1:0] joy_clk;
   logic [P*2-1:0] joy_di;
   logic [P*B-1:0] state_n;

   int pass_cnt = 0;
   int total_cnt = 0;
   int exp_q[$];
   logic [15:0] pat0 = 16'hA5F0;
   logic [15:0] pat1 = 16'h3C3E;

   snes_joy_serializer #(
      .C_ports(P), .C_bits(B), .C_debounce_bits(2), .C_turbo_bits(4)
   ) dut (
      .clk(clk), .reset(reset), .buttons_n(buttons_n), .turbo_mask(turbo_mask),
      .joy_strb(joy_strb), .joy_clk(joy_clk), .joy_di(joy_di), .state_n(state_n)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input int p);
      joy_clk[p] = 1'b1;
      step();
      joy_clk[p] = 1'b0;
      step();
   endtask

   task automatic strobe();
      joy_strb = 1'b1;
      step();
      joy_strb = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; joy_clk = '1; joy_strb = 1'b0;
      buttons_n = '1; turbo_mask = '0;
      step(3);
      total_cnt++;
      if (joy_di !== 4'b1111) $display("FAIL reset_joy_di got=%b exp=1111", joy_di);
      else pass_cnt++;
      total_cnt++;
      if (state_n !== '1) $display("FAIL reset_state_n got=%h exp=ffffffff", state_n);
      else pass_cnt++;
      reset = 1'b0;
      step(2);
      joy_clk = '0;
      step();
      // 15 genuine shifts of an all-ones register still read 1; a spurious one would not
      for (int i = 0; i < 15; i++) begin
         joy_clk = '1; step(); joy_clk = '0; step();
      end
      total_cnt++;
      if (joy_di !== 4'b1111) $display("FAIL release_no_shift got=%b exp=1111", joy_di);
      else pass_cnt++;
      joy_clk = '1; step(); joy_clk = '0; step();
      total_cnt++;
      if (joy_di !== 4'b1010) $display("FAIL sixteenth_shift got=%b exp=1010", joy_di);
      else pass_cnt++;
   endtask

   task automatic test_load_shift();
      buttons_n = {pat1, pat0};
      step(30);
      total_cnt++;
      if (state_n !== {pat1, pat0}) $display("FAIL debounced_image got=%h exp=%h", state_n, {pat1, pat0});
      else pass_cnt++;
      strobe();
      for (int i = 0; i < 16; i++) exp_q.push_back(int'(pat0[i]));
      for (int i = 0; i < 3; i++) exp_q.push_back(0);
      for (int i = 0; i < 19; i++) begin
         int e;
         if (i > 0) pulse(0);
         e = exp_q.pop_front();
         total_cnt++;
         if (joy_di[1:0] !== {1'b1, e[0]}) $display("FAIL shift_bit%0d got=%b exp=1%0d", i, joy_di[1:0], e);
         else pass_cnt++;
      end
      total_cnt++;
      if (joy_di[3:2] !== {1'b1, pat1[0]}) $display("FAIL port1_isolated got=%b exp=1%b", joy_di[3:2], pat1[0]);
      else pass_cnt++;
   endtask

   task automatic test_glitch();
      bit ok = 1'b1;
      int n = 0;
      bit seen = 1'b0;
      buttons_n[4] = 1'b0;
      for (int i = 0; i < 4; i++) begin step(); if (state_n[4] !== 1'b1) ok = 1'b0; end
      buttons_n[4] = 1'b1;
      for (int i = 0; i < 30; i++) begin step(); if (state_n[4] !== 1'b1) ok = 1'b0; end
      total_cnt++;
      if (!ok) $display("FAIL glitch_rejected got=0 exp=1");
      else pass_cnt++;
      buttons_n[4] = 1'b0;
      while (!seen && n < 30) begin
         step(); n++;
         if (state_n[4] === 1'b0) seen = 1'b1;
      end
      total_cnt++;
      if (!seen || n > 17) $display("FAIL debounce_latency got=%0d cycles exp<=17", n);
      else pass_cnt++;
      buttons_n[4] = 1'b1;
      step(30);
   endtask

   task automatic test_turbo();
      logic v;
      bit ok = 1'b1;
      int n = 0;
      turbo_mask[1] = 1'b1;
      v = state_n[1];
      while (state_n[1] === v && n < 20) begin step(); n++; end
      total_cnt++;
      if (n >= 20) $display("FAIL turbo_toggle_timeout got=%0d cycles exp<20", n);
      else pass_cnt++;
      v = state_n[1];
      for (int k = 1; k < 32; k++) begin
         logic e;
         step();
         e = v ^ logic'((k / 8) % 2);
         total_cnt++;
         if (state_n[1] !== e) $display("FAIL turbo_phase_k%0d got=%b exp=%b", k, state_n[1], e);
         else pass_cnt++;
      end
      buttons_n[1] = 1'b1;
      step(30);
      for (int i = 0; i < 20; i++) begin step(); if (state_n[1] !== 1'b1) ok = 1'b0; end
      total_cnt++;
      if (!ok) $display("FAIL turbo_released got=0 exp=1");
      else pass_cnt++;
      turbo_mask = '0;
      buttons_n[1] = pat0[1];
      step(30);
   endtask

   task automatic test_collision();
      strobe();
      for (int i = 0; i < 5; i++) pulse(0);
      total_cnt++;
      if (joy_di[1:0] !== {1'b1, pat0[5]}) $display("FAIL pre_collision got=%b exp=1%b", joy_di[1:0], pat0[5]);
      else pass_cnt++;
      joy_clk[0] = 1'b1; joy_strb = 1'b1;
      step();
      joy_strb = 1'b0;
      total_cnt++;
      if (joy_di[1:0] !== {1'b1, pat0[0]}) $display("FAIL collision_load got=%b exp=1%b", joy_di[1:0], pat0[0]);
      else pass_cnt++;
      step();
      joy_clk[0] = 1'b0;
      step();
      total_cnt++;
      if (joy_di[1:0] !== {1'b1, pat0[0]}) $display("FAIL collision_hold got=%b exp=1%b", joy_di[1:0], pat0[0]);
      else pass_cnt++;
      for (int i = 1; i < 5; i++) exp_q.push_back(int'(pat0[i]));
      for (int i = 1; i < 5; i++) begin
         int e;
         pulse(0);
         e = exp_q.pop_front();
         total_cnt++;
         if (joy_di[1:0] !== {1'b1, e[0]}) $display("FAIL after_collision_bit%0d got=%b exp=1%0d", i, joy_di[1:0], e);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid_shift();
      strobe();
      for (int i = 0; i < 5; i++) pulse(0);
      reset = 1'b1;
      #1;
      total_cnt++;
      if (joy_di !== 4'b1111) $display("FAIL midshift_reset_joy_di got=%b exp=1111", joy_di);
      else pass_cnt++;
      total_cnt++;
      if (state_n !== '1) $display("FAIL midshift_reset_state_n got=%h exp=ffffffff", state_n);
      else pass_cnt++;
      step(2);
      reset = 1'b0;
      step(30);
      strobe();
      for (int i = 0; i < 16; i++) exp_q.push_back(int'(pat0[i]));
      exp_q.push_back(0);
      for (int i = 0; i < 17; i++) begin
         int e;
         if (i > 0) pulse(0);
         e = exp_q.pop_front();
         total_cnt++;
         if (joy_di[1:0] !== {1'b1, e[0]}) $display("FAIL reload_bit%0d got=%b exp=1%0d", i, joy_di[1:0], e);
         else pass_cnt++;
      end
   endtask

   initial begin
      reset = 1'b1; joy_strb = 1'b0; joy_clk = '1;
      buttons_n = '1; turbo_mask = '0;
      test_reset();
      test_load_shift();
      test_glitch();
      test_turbo();
      test_collision();
      test_reset_mid_shift();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
